// File: rtl/dm_mem_if.sv
// dm_mem_if: word-wide valid/ready data-memory port between the access unit and data memory
interface dm_mem_if #(parameter int AW = 32);
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  modport master (output mem_req, mem_we, mem_be, mem_addr, mem_wdata, input mem_ready, mem_rdata);
  modport slave (input mem_req, mem_we, mem_be, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/dm_access_unit.sv
// dm_access_unit: EX/MEM data-memory access with lane steering, load extension and pipeline stall
// MISALIGN_TRAP_EN: trap misaligned word accesses with bus_err instead of accessing the aligned word
module dm_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req_valid,
  input  logic          i_mem_wr,
  input  logic          i_dm_sign_ext,
  input  logic [1:0]    i_byte_width,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic          o_stall,
  output logic [31:0]   o_rdata,
  output logic          o_rdata_valid,
  output logic          o_bus_err,
  dm_mem_if.master      mem
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t          r_state, w_next;
  logic            r_req, r_we, r_sign, r_word, r_rdata_valid, r_bus_err;
  logic [3:0]      r_be;
  logic [1:0]      r_off;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata, r_rdata;
  logic [CW-1:0]   r_cnt;
  logic            w_go, w_word, w_mis, w_tmo;
  logic [31:0]     w_sh, w_load;
  assign w_go   = i_req_valid & i_byte_width[0];
  assign w_word = i_byte_width[1];
`ifdef MISALIGN_TRAP_EN
  assign w_mis  = w_word & (i_addr[1:0] != 2'b00);
`else
  assign w_mis  = 1'b0;
`endif
  assign w_tmo  = (TIMEOUT != 0) && (r_cnt == LAST) && !mem.mem_ready;
  assign w_sh   = mem.mem_rdata >> {r_off, 3'b000};
  assign w_load = r_word ? mem.mem_rdata : {{24{r_sign & w_sh[7]}}, w_sh[7:0]};
  assign o_stall = !rst & ((r_state == IDLE & w_go) | r_state == WAIT);
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_bus_err     = r_bus_err;
  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_be    = r_be;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_go ? (w_mis ? DONE : WAIT) : IDLE) :
             r_state == WAIT ? ((mem.mem_ready | w_tmo) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_be <= 4'b0000;
      r_addr <= '0;
      r_wdata <= 32'h0;
      r_sign <= 1'b0;
      r_word <= 1'b0;
      r_off <= 2'b00;
      r_cnt <= '0;
      r_rdata <= 32'h0;
      r_rdata_valid <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_bus_err <= 1'b0;
      if (r_state == IDLE && w_go) begin
        r_req <= !w_mis;
        r_bus_err <= w_mis;
        r_we <= i_mem_wr;
        r_be <= w_word ? 4'b1111 : 4'b0001 << i_addr[1:0];
        r_addr <= {i_addr[AW-1:2], 2'b00};
        r_wdata <= w_word ? i_wdata : {4{i_wdata[7:0]}};
        r_sign <= i_dm_sign_ext;
        r_word <= w_word;
        r_off <= i_addr[1:0];
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (mem.mem_ready) begin
          r_req <= 1'b0;
          if (!r_we) begin
            r_rdata <= w_load;
            r_rdata_valid <= 1'b1;
          end
        end else if (w_tmo) begin
          r_req <= 1'b0;
          r_bus_err <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: directed checks of loads, stores, timeout, no-access, reset and alignment handling
module tb_dm_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, mem_wr = 1'b0, sign_ext = 1'b0;
  logic [1:0]  byte_width = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        stall, rdata_valid, bus_err;
  logic [31:0] rdata;
  int          total = 0, bad = 0;
  int          stalls;
  logic        saw_req, o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata;
  dm_mem_if #(.AW(32)) mif ();
  dm_access_unit #(.TIMEOUT(16), .AW(32)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_mem_wr(mem_wr), .i_dm_sign_ext(sign_ext),
    .i_byte_width(byte_width), .i_addr(addr), .i_wdata(wdata), .o_stall(stall), .o_rdata(rdata),
    .o_rdata_valid(rdata_valid), .o_bus_err(bus_err), .mem(mif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  // Issues one access at a negedge and answers mem_req after `delay` wait cycles (-1 never);
  // returns at the first non-stalled negedge with the bus fields seen on the first request cycle.
  task automatic op(input logic wr, input logic se, input logic [1:0] bw, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] rd, input int delay);
    int w;
    @(negedge clk);
    req_valid = 1'b1; mem_wr = wr; sign_ext = se; byte_width = bw; addr = a; wdata = wd;
    mif.mem_rdata = rd; mif.mem_ready = 1'b0;
    stalls = 0; saw_req = 1'b0; w = 0;
    o_we = 1'b0; o_be = 4'h0; o_addr = 32'h0; o_wdata = 32'h0;
    #1;
    for (int c = 0; c < 40 && stall; c++) begin
      stalls++;
      if (mif.mem_req && !saw_req) begin
        saw_req = 1'b1; o_we = mif.mem_we; o_be = mif.mem_be; o_addr = mif.mem_addr; o_wdata = mif.mem_wdata;
      end
      if (mif.mem_req) begin
        mif.mem_ready = (w == delay);
        w++;
      end else mif.mem_ready = 1'b0;
      @(negedge clk);
      #1;
    end
  endtask
  task automatic release_op();
    req_valid = 1'b0; byte_width = 2'b00; mif.mem_ready = 1'b0;
    @(negedge clk);
    #1;
  endtask
  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'h0;
    #12;
    chk("rst_req", {31'b0, mif.mem_req}, 32'h0);
    chk("rst_be", {28'b0, mif.mem_be}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {30'b0, rdata_valid, bus_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    op(1'b0, 1'b0, 2'b11, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    chk("lw_stalls", stalls, 2);
    chk("lw_addr", o_addr, 32'h10);
    chk("lw_be", {28'b0, o_be}, 32'hF);
    chk("lw_we", {31'b0, o_we}, 32'h0);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_valid", {31'b0, rdata_valid}, 32'h1);
    chk("lw_req_drop", {31'b0, mif.mem_req}, 32'h0);
    release_op();
    chk("lw_valid_pulse", {31'b0, rdata_valid}, 32'h0);
    op(1'b0, 1'b1, 2'b01, 32'h13, 32'h0, 32'h80112233, 0);
    chk("lb_be", {28'b0, o_be}, 32'h8);
    chk("lb_addr", o_addr, 32'h10);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_valid", {31'b0, rdata_valid}, 32'h1);
    release_op();
    op(1'b0, 1'b0, 2'b01, 32'h13, 32'h0, 32'h80112233, 1);
    chk("lbu_stalls", stalls, 3);
    chk("lbu_rdata", rdata, 32'h00000080);
    release_op();
    op(1'b0, 1'b1, 2'b01, 32'h11, 32'h0, 32'h80112233, 0);
    chk("lb1_be", {28'b0, o_be}, 32'h2);
    chk("lb1_rdata", rdata, 32'h00000022);
    release_op();
    op(1'b1, 1'b0, 2'b01, 32'h21, 32'h000000A5, 32'hFFFFFFFF, 2);
    chk("sb_stalls", stalls, 4);
    chk("sb_be", {28'b0, o_be}, 32'h2);
    chk("sb_wdata", o_wdata, 32'hA5A5A5A5);
    chk("sb_addr", o_addr, 32'h20);
    chk("sb_we", {31'b0, o_we}, 32'h1);
    chk("sb_no_valid", {31'b0, rdata_valid}, 32'h0);
    chk("sb_rdata_hold", rdata, 32'h00000022);
    release_op();
    op(1'b1, 1'b0, 2'b11, 32'h40, 32'h12345678, 32'h0, -1);
    chk("to_stalls", stalls, 17);
    chk("to_wdata", o_wdata, 32'h12345678);
    chk("to_bus_err", {31'b0, bus_err}, 32'h1);
    chk("to_req_drop", {31'b0, mif.mem_req}, 32'h0);
    release_op();
    chk("to_err_pulse", {31'b0, bus_err}, 32'h0);
    for (int k = 0; k < 4; k += 2) begin
      @(negedge clk);
      req_valid = 1'b1; byte_width = 2'(k); mif.mem_ready = 1'b1;
      #1;
      chk("noacc_stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      #1;
      chk("noacc_req", {31'b0, mif.mem_req}, 32'h0);
      chk("noacc_stall2", {31'b0, stall}, 32'h0);
      release_op();
    end
    @(negedge clk);
    req_valid = 1'b1; mem_wr = 1'b0; byte_width = 2'b11; addr = 32'h80; mif.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rw_req_up", {31'b0, mif.mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rw_req_drop", {31'b0, mif.mem_req}, 32'h0);
    chk("rw_stall", {31'b0, stall}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_idle", {30'b0, stall, rdata_valid}, 32'h0);
`ifdef MISALIGN_TRAP_EN
    op(1'b0, 1'b0, 2'b11, 32'h2, 32'h0, 32'h12345678, 0);
    chk("mis_stalls", stalls, 1);
    chk("mis_no_req", {31'b0, saw_req}, 32'h0);
    chk("mis_bus_err", {31'b0, bus_err}, 32'h1);
    chk("mis_no_valid", {31'b0, rdata_valid}, 32'h0);
`else
    op(1'b0, 1'b0, 2'b11, 32'h2, 32'h0, 32'h12345678, 0);
    chk("mis_stalls", stalls, 2);
    chk("mis_addr", o_addr, 32'h0);
    chk("mis_be", {28'b0, o_be}, 32'hF);
    chk("mis_rdata", rdata, 32'h12345678);
    chk("mis_no_err", {31'b0, bus_err}, 32'h0);
`endif
    release_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
